// File: rtl/ipc_comlink.sv
// IPC end of the COMDATA/COMCTL link: start-bit qualify, two COMCTL pulses per frame,
// MSB-first byte assembly both ways. Define IPC_COMLINK_TIMEOUT_EN to discard stale partial bytes.
module ipc_comlink #(
  parameter int PULSE_LEN   = 8,
  parameter int GAP_LEN     = 8,
  parameter int SETUP_LEN   = 4,
  parameter int TIMEOUT_LEN = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_11m,
  output logic       comctrl,
  input  logic       comdata_in,
  output logic       comdata_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       busy,
  output logic       rx_abort
);
  typedef enum logic [2:0] {S_IDLE, S_QUAL, S_P1, S_G1, S_P2, S_H2, S_WAITE} state_t;

  localparam logic [7:0]  PULSE_T = 8'(PULSE_LEN);
  localparam logic [7:0]  GAP_T   = 8'(GAP_LEN);
  localparam logic [7:0]  SETUP_T = 8'(SETUP_LEN);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       comctrl_q, comctrl_d;
  logic       cdo_q, cdo_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       pend_q, pend_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ovr_q, ovr_d;
  logic       expired;

`ifdef IPC_COMLINK_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        abort_q, abort_d;
`endif

  // A loaded timer of N expires on the Nth tick after loading.
  assign expired = (timer_q == 8'd1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    comctrl_d  = comctrl_q;
    cdo_d      = cdo_q;
    bitcnt_d   = bitcnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    pend_d     = pend_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;

    if (rx_ack) rx_valid_d = 1'b0;
    if (tx_load && tx_ready) begin
      tx_sh_d = tx_data;
      pend_d  = 1'b1;
    end

    if (ce_11m) begin
      case (state_q)
        S_IDLE: if (!comdata_in) begin
          timer_d = SETUP_T;
          state_d = S_QUAL;
        end
        S_QUAL: begin
          if (comdata_in) state_d = S_IDLE;
          else if (expired) begin
            comctrl_d = 1'b0;
            timer_d   = PULSE_T;
            state_d   = S_P1;
          end else timer_d = timer_q - 8'd1;
        end
        S_P1: begin
          if (expired) begin
            comctrl_d = 1'b1;
            timer_d   = GAP_T;
            state_d   = S_G1;
          end else timer_d = timer_q - 8'd1;
        end
        S_G1: begin
          if (expired) begin
            rx_sh_d   = {rx_sh_q[6:0], comdata_in};
            cdo_d     = tx_sh_q[7];
            comctrl_d = 1'b0;
            timer_d   = PULSE_T;
            state_d   = S_P2;
          end else timer_d = timer_q - 8'd1;
        end
        S_P2: begin
          if (expired) begin
            comctrl_d = 1'b1;
            timer_d   = GAP_T;
            state_d   = S_H2;
          end else timer_d = timer_q - 8'd1;
        end
        S_H2: begin
          if (expired) begin
            cdo_d    = 1'b1;
            tx_sh_d  = {tx_sh_q[6:0], 1'b1};
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = S_WAITE;
            if (bitcnt_q == 3'd7) begin
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              pend_d     = 1'b0;
              if (rx_valid_q && !rx_ack) ovr_d = 1'b1;
            end
          end else timer_d = timer_q - 8'd1;
        end
        S_WAITE: if (comdata_in) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

`ifdef IPC_COMLINK_TIMEOUT_EN
    abort_d    = 1'b0;
    idle_cnt_d = idle_cnt_q;
    if (state_q != S_IDLE) idle_cnt_d = '0;
    else if (ce_11m && comdata_in && bitcnt_q != 3'd0) begin
      if (idle_cnt_q == TO_LAST) begin
        idle_cnt_d = '0;
        bitcnt_d   = 3'd0;
        rx_sh_d    = 8'h00;
        tx_sh_d    = 8'hFF;
        pend_d     = 1'b0;
        abort_d    = 1'b1;
      end else idle_cnt_d = idle_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      comctrl_q  <= 1'b1;
      cdo_q      <= 1'b1;
      bitcnt_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      tx_sh_q    <= 8'hFF;
      pend_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      comctrl_q  <= comctrl_d;
      cdo_q      <= cdo_d;
      bitcnt_q   <= bitcnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      pend_q     <= pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef IPC_COMLINK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      abort_q    <= abort_d;
    end
  end
  assign rx_abort = abort_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
  assign rx_abort       = 1'b0;
`endif

  assign comctrl     = comctrl_q;
  assign comdata_out = cdo_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = ovr_q;
  assign tx_ready    = (bitcnt_q == 3'd0) && (state_q == S_IDLE) && !pend_q;
  assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_ipc_comlink.sv
// Self-checking bench for ipc_comlink: host-side frame model, byte vector table and scoreboard.
module tb_ipc_comlink;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_11m = 1'b0;
  logic       comctrl, comdata_out, rx_valid, rx_overrun, tx_ready, busy, rx_abort;
  logic       comdata_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  ipc_comlink #(.PULSE_LEN(8), .GAP_LEN(GAP), .SETUP_LEN(4), .TIMEOUT_LEN(100)) dut (
    .clk(clk), .reset_n(reset_n), .ce_11m(ce_11m), .comctrl(comctrl),
    .comdata_in(comdata_in), .comdata_out(comdata_out), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .busy(busy), .rx_abort(rx_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end, got running want finished");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [7:0] rx; logic ld; logic [7:0] tx; logic [7:0] exp_ret; } vec_t;
  typedef struct { logic [7:0] rx; logic [7:0] ret; } exp_t;
  exp_t sb[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // sel 0 = comctrl, 1 = busy; bounded wait for the given level
  task automatic wait_lvl(input int sel, input logic lvl, input string nm);
    logic v;
    for (int i = 0; i < 500; i++) begin
      v = (sel == 0) ? comctrl : busy;
      if (v === lvl) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_%s: got timeout want level %b", nm, lvl);
  endtask

  task automatic frame(input logic d, input bit ack_done, output logic ret);
    comdata_in = 1'b0;
    wait_lvl(0, 1'b0, "p1");
    comdata_in = d;
    wait_lvl(0, 1'b1, "g1");
    wait_lvl(0, 1'b0, "p2");
    ret = comdata_out;
    wait_lvl(0, 1'b1, "h2");
    comdata_in = 1'b1;
    if (ack_done) begin
      // H2 expires GAP ticks after the rising edge just observed
      repeat (GAP - 1) step();
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
    end
    wait_lvl(1, 1'b0, "idle");
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_last, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      frame(b[i], ack_last && (i == 0), rb);
      r[i] = rb;
      chk1("tx_ready_frame", tx_ready, (i == 0));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    comdata_in = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  initial begin
    vec_t       vecs[4];
    exp_t       e;
    logic [7:0] r;
    logic       rb;
    int         nab, first;
    logic       exp_cc;

    vecs[0] = '{rx: 8'hA5, ld: 1'b0, tx: 8'h00, exp_ret: 8'hFF};
    vecs[1] = '{rx: 8'hFF, ld: 1'b1, tx: 8'h3C, exp_ret: 8'h3C};
    vecs[2] = '{rx: 8'h00, ld: 1'b1, tx: 8'h81, exp_ret: 8'h81};
    vecs[3] = '{rx: 8'h5A, ld: 1'b1, tx: 8'hC3, exp_ret: 8'hC3};

    // reset with ce low: reset must not depend on ce
    step(); step(); step();
    chk1("rst_comctrl", comctrl, 1'b1);
    chk1("rst_cdo", comdata_out, 1'b1);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_overrun", rx_overrun, 1'b0);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_abort", rx_abort, 1'b0);

    // no ce, no progress
    reset_n = 1'b1;
    comdata_in = 1'b0;
    repeat (10) step();
    chk1("no_ce_busy", busy, 1'b0);
    chk1("no_ce_comctrl", comctrl, 1'b1);

    // frame timing from the first tick that sees the start bit
    ce_11m = 1'b1;
    do_reset();
    comdata_in = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      step();
      exp_cc = !((k >= 4 && k <= 11) || (k >= 20 && k <= 27));
      chk1($sformatf("timing_comctrl_t%0d", k), comctrl, exp_cc);
      chk1($sformatf("timing_busy_t%0d", k), busy, 1'b1);
      chk1($sformatf("timing_cdo_t%0d", k), comdata_out, 1'b1);
    end
    comdata_in = 1'b1;
    step(); step();
    chk1("timing_back_idle", busy, 1'b0);

    // byte vectors
    do_reset();
    foreach (vecs[n]) begin
      if (vecs[n].ld) begin
        tx_data = vecs[n].tx;
        tx_load = 1'b1;
        step();
        tx_load = 1'b0;
        chk1("tx_ready_after_load", tx_ready, 1'b0);
        tx_data = ~vecs[n].tx;
        tx_load = 1'b1;
        step();
        tx_load = 1'b0;
      end
      sb.push_back('{rx: vecs[n].rx, ret: vecs[n].exp_ret});
      send_byte(vecs[n].rx, 1'b0, r);
      chk1("vec_rx_valid", rx_valid, 1'b1);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got empty want entry");
      end else begin
        e = sb.pop_front();
        chk8($sformatf("vec%0d_rx_data", n), rx_data, e.rx);
        chk8($sformatf("vec%0d_return", n), r, e.ret);
      end
      chk1("vec_overrun", rx_overrun, 1'b0);
      pulse_ack();
      chk1("vec_ack_clears", rx_valid, 1'b0);
    end

    // partial byte then long idle
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, rb);
    nab = 0;
    first = -1;
    for (int i = 1; i <= 150; i++) begin
      step();
      if (rx_abort === 1'b1) begin
        nab++;
        if (first < 0) first = i;
      end
    end
`ifdef IPC_COMLINK_TIMEOUT_EN
    chk8("abort_pulses", 8'(nab), 8'd1);
    chk8("abort_tick", 8'(first), 8'd100);
    chk8("abort_keeps_rx_data", rx_data, 8'h5A);
    chk1("abort_tx_ready", tx_ready, 1'b1);
    sb.push_back('{rx: 8'h96, ret: 8'hFF});
    send_byte(8'h96, 1'b0, r);
`else
    chk8("abort_pulses", 8'(nab), 8'd0);
    sb.push_back('{rx: 8'hEA, ret: 8'hFF});
    for (int i = 4; i >= 0; i--) begin
      frame(i[0] ? 1'b1 : 1'b0, 1'b0, rb);
      r[i] = rb;
    end
    r[7:5] = 3'b111;
`endif
    e = sb.pop_front();
    chk8("after_idle_rx_data", rx_data, e.rx);
    chk8("after_idle_return", r, e.ret);
    chk1("after_idle_valid", rx_valid, 1'b1);
    pulse_ack();

    // overrun: two bytes, no ack
    send_byte(8'h11, 1'b0, r);
    send_byte(8'h22, 1'b0, r);
    chk1("overrun_set", rx_overrun, 1'b1);
    chk8("overrun_data", rx_data, 8'h22);

    // reset in the middle of pulse 1
    comdata_in = 1'b0;
    wait_lvl(0, 1'b0, "rst_p1");
    reset_n = 1'b0;
    step();
    chk1("midrst_comctrl", comctrl, 1'b1);
    chk1("midrst_cdo", comdata_out, 1'b1);
    chk1("midrst_rx_valid", rx_valid, 1'b0);
    chk1("midrst_overrun", rx_overrun, 1'b0);
    chk1("midrst_tx_ready", tx_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    comdata_in = 1'b1;
    step();
    reset_n = 1'b1;
    nab = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (comctrl !== 1'b1) nab++;
    end
    chk8("midrst_no_pulses", 8'(nab), 8'd0);

    // ack on the completing clk: new byte wins, no overrun
    send_byte(8'h33, 1'b0, r);
    send_byte(8'h44, 1'b1, r);
    chk1("simul_valid", rx_valid, 1'b1);
    chk1("simul_overrun", rx_overrun, 1'b0);
    chk8("simul_data", rx_data, 8'h44);
    pulse_ack();
    pulse_ack();
    chk1("ack_when_empty", rx_valid, 1'b0);
    chk1("ack_when_empty_ovr", rx_overrun, 1'b0);

    // two-tick glitch must not start a frame
    comdata_in = 1'b0;
    step(); step();
    comdata_in = 1'b1;
    nab = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (comctrl !== 1'b1) nab++;
    end
    chk8("glitch_no_pulse", 8'(nab), 8'd0);
    chk1("glitch_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
